// File: rtl/isqrt_pkg.sv
// Shared definitions for the isqrt_rv square-root block: FSM state encoding
// and helpers that derive the datapath widths from the block parameters.
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_BIT_WIDTH       = 12;
    localparam int DEFAULT_STEPS_PER_CYCLE = 1;

    // Root has one bit per radicand bit pair.
    function automatic int root_width(input int bit_width);
        return bit_width / 2;
    endfunction

    // Internal remainder carries two guard bits so that (rem << 2) | pair
    // never overflows before the trial subtraction.
    function automatic int rem_width(input int bit_width);
        return bit_width / 2 + 2;
    endfunction

    // Final remainder is bounded by 2*root, so one bit above the root suffices.
    function automatic int rem_out_width(input int bit_width);
        return bit_width / 2 + 1;
    endfunction

    // Number of clock edges spent in CALC.
    function automatic int num_iters(input int bit_width, input int steps);
        if (steps < 1) begin
            return 1;
        end
        return bit_width / (2 * steps);
    endfunction

    function automatic int cnt_width(input int bit_width, input int steps);
        return $clog2(num_iters(bit_width, steps) + 1);
    endfunction

    // Legal parameter combinations: even width >= 4, 1..3 digits per clock,
    // and the digit count dividing the number of root bits.
    function automatic bit params_ok(input int bit_width, input int steps);
        if ((bit_width % 2) != 0 || bit_width < 4) begin
            return 1'b0;
        end
        if (steps < 1 || steps > 3) begin
            return 1'b0;
        end
        return ((bit_width / 2) % steps) == 0;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: bring down the next radicand bit
// pair, try to subtract (root<<2)|1 and set the new root bit accordingly.
module isqrt_step #(
    parameter int ROOT_W = 6
) (
    input  logic [ROOT_W-1:0] root_prev,
    input  logic [ROOT_W+1:0] rem_prev,
    input  logic [1:0]        pair,
    output logic [ROOT_W-1:0] root_next,
    output logic [ROOT_W+1:0] rem_next
);

    logic [ROOT_W+1:0] trial_rem_s;
    logic [ROOT_W+1:0] trial_sub_s;

    // Partial remainder with the next bit pair appended.
    assign trial_rem_s = (rem_prev << 2) | {{ROOT_W{1'b0}}, pair};
    // Trial subtrahend (root << 2) | 1, exactly the remainder width.
    assign trial_sub_s = {root_prev, 2'b01};

    // Restoring decision: keep the subtraction only when it does not go negative.
    always_comb begin
        root_next = root_prev << 1;
        rem_next  = trial_rem_s;
        if (trial_rem_s >= trial_sub_s) begin
            root_next = (root_prev << 1) | ROOT_W'(1'b1);
            rem_next  = trial_rem_s - trial_sub_s;
        end else begin
            root_next = root_prev << 1;
            rem_next  = trial_rem_s;
        end
    end

endmodule

// File: rtl/isqrt_rv.sv
// Iterative integer square root with valid/ready handshakes on both sides.
// A radicand is accepted in IDLE, resolved STEPS_PER_CYCLE root digits per
// clock in CALC, and the result is held in DONE until the consumer takes it.
module isqrt_rv
    import isqrt_pkg::*;
#(
    parameter int BIT_WIDTH       = DEFAULT_BIT_WIDTH,
    parameter int STEPS_PER_CYCLE = DEFAULT_STEPS_PER_CYCLE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_WIDTH-1:0]   x_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIT_WIDTH/2-1:0] root,
    output logic [BIT_WIDTH/2:0]   rem
);

    localparam int RW    = root_width(BIT_WIDTH);
    localparam int REMW  = rem_width(BIT_WIDTH);
    localparam int OUTW  = rem_out_width(BIT_WIDTH);
    localparam int N     = num_iters(BIT_WIDTH, STEPS_PER_CYCLE);
    localparam int CW    = cnt_width(BIT_WIDTH, STEPS_PER_CYCLE);
    localparam int SHIFT = 2 * STEPS_PER_CYCLE;

    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!params_ok(BIT_WIDTH, STEPS_PER_CYCLE)) begin : g_param_check
        $error("isqrt_rv: BIT_WIDTH must be even and >= 4, STEPS_PER_CYCLE in 1..3 and dividing BIT_WIDTH/2");
    end

    state_t                state_r;
    logic [CW-1:0]         cnt_r;
    logic [BIT_WIDTH-1:0]  x_sh_r;
    logic [RW-1:0]         root_acc_r;
    logic [REMW-1:0]       rem_acc_r;
    logic [RW-1:0]         root_r;
    logic [OUTW-1:0]       rem_r;
    logic                  in_ready_r;
    logic                  out_valid_r;

    logic [STEPS_PER_CYCLE:0][RW-1:0]   root_chain_s;
    logic [STEPS_PER_CYCLE:0][REMW-1:0] rem_chain_s;

    assign root_chain_s[0] = root_acc_r;
    assign rem_chain_s[0]  = rem_acc_r;

    // Chain of digit steps; step g consumes the g-th bit pair from the top.
    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        isqrt_step #(
            .ROOT_W (RW)
        ) u_step (
            .root_prev (root_chain_s[g]),
            .rem_prev  (rem_chain_s[g]),
            .pair      (x_sh_r[BIT_WIDTH-1-2*g -: 2]),
            .root_next (root_chain_s[g+1]),
            .rem_next  (rem_chain_s[g+1])
        );
    end

    // Control FSM with counter, radicand shifter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            x_sh_r      <= {BIT_WIDTH{1'b0}};
            root_acc_r  <= {RW{1'b0}};
            rem_acc_r   <= {REMW{1'b0}};
            root_r      <= {RW{1'b0}};
            rem_r       <= {OUTW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        state_r    <= CALC;
                        x_sh_r     <= x_in;
                        root_acc_r <= {RW{1'b0}};
                        rem_acc_r  <= {REMW{1'b0}};
                        cnt_r      <= CNT_LOAD;
                        in_ready_r <= 1'b0;
                    end
                end
                CALC: begin
                    x_sh_r     <= x_sh_r << SHIFT;
                    root_acc_r <= root_chain_s[STEPS_PER_CYCLE];
                    rem_acc_r  <= rem_chain_s[STEPS_PER_CYCLE];
                    cnt_r      <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        // Final digits resolved: publish the result.
                        state_r     <= DONE;
                        root_r      <= root_chain_s[STEPS_PER_CYCLE];
                        rem_r       <= OUTW'(rem_chain_s[STEPS_PER_CYCLE]);
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CW{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign root      = root_r;
    assign rem       = rem_r;

endmodule

// File: tb/tb_isqrt_rv.sv
// Scoreboard bench for isqrt_rv: a default 12-bit/1-digit instance with
// directed and random traffic, plus a 16-bit/2-digit instance with random
// traffic. Expected results come from a plain floor(sqrt) reference model.
module tb_isqrt_rv;

    localparam int N_A = 6;
    localparam int N_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [11:0] x_a;
    logic [5:0]  root_a;
    logic [6:0]  rem_a;

    logic        reset_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [15:0] x_b;
    logic [7:0]  root_b;
    logic [8:0]  rem_b;

    typedef struct {
        int root;
        int rem;
        int acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_a  = 0;
    int   hs_b  = 0;
    bit   b_done = 1'b0;

    isqrt_rv #(.BIT_WIDTH(12), .STEPS_PER_CYCLE(1)) dut_a (
        .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .x_in(x_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .root(root_a), .rem(rem_a)
    );

    isqrt_rv #(.BIT_WIDTH(16), .STEPS_PER_CYCLE(2)) dut_b (
        .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .x_in(x_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .root(root_b), .rem(rem_b)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: largest r with r*r <= x, remainder x - r*r.
    function automatic exp_t model(input int x, input int acc);
        exp_t e;
        int   r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        e.root = r;
        e.rem  = x - r * r;
        e.acc  = acc;
        return e;
    endfunction

    task automatic send_a(input logic [11:0] x);
        int t = 0;
        @(negedge clk);
        in_valid_a = 1'b1;
        x_a = x;
        while (!in_ready_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("a_accept", in_ready_a, 1);
        if (in_ready_a) q_a.push_back(model(int'(x), cyc + 1));
        @(negedge clk);
        in_valid_a = 1'b0;
        x_a = 12'($urandom);
    endtask

    task automatic wait_hs_a(input int target);
        int t = 0;
        while (hs_a < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("a_handshake_seen", hs_a >= target, 1);
    endtask

    task automatic send_b(input logic [15:0] x);
        int t = 0;
        @(negedge clk);
        in_valid_b = 1'b1;
        x_b = x;
        while (!in_ready_b && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("b_accept", in_ready_b, 1);
        if (in_ready_b) q_b.push_back(model(int'(x), cyc + 1));
        @(negedge clk);
        in_valid_b = 1'b0;
        x_b = 16'($urandom);
    endtask

    // Monitor A: compare on each new result, count completed handshakes.
    initial begin : mon_a
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_a) begin
                if (out_valid_a && !prev) begin
                    check("a_result_expected", q_a.size() > 0, 1);
                    if (q_a.size() > 0) begin
                        check("a_latency", cyc - q_a[0].acc, N_A);
                        check("a_root", root_a, q_a[0].root);
                        check("a_rem", rem_a, q_a[0].rem);
                        check("a_rem_bound", rem_a <= 2 * root_a, 1);
                    end
                end
                if (out_valid_a && out_ready_a) begin
                    if (q_a.size() > 0) void'(q_a.pop_front());
                    hs_a++;
                end
            end
            prev = out_valid_a && !reset_a;
        end
    end

    // Monitor B: same checks for the 16-bit, two-digit instance.
    initial begin : mon_b
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_b) begin
                if (out_valid_b && !prev) begin
                    check("b_result_expected", q_b.size() > 0, 1);
                    if (q_b.size() > 0) begin
                        check("b_latency", cyc - q_b[0].acc, N_B);
                        check("b_root", root_b, q_b[0].root);
                        check("b_rem", rem_b, q_b[0].rem);
                    end
                end
                if (out_valid_b && out_ready_b) begin
                    if (q_b.size() > 0) void'(q_b.pop_front());
                    hs_b++;
                end
            end
            prev = out_valid_b && !reset_b;
        end
    end

    // Driver B: corner radicands then random ones, consumer always ready.
    initial begin : drv_b
        logic [15:0] x;
        int t;
        reset_b = 1'b1; in_valid_b = 1'b0; out_ready_b = 1'b1; x_b = 16'd0;
        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            case (i)
                0:       x = 16'd0;
                1:       x = 16'hFFFF;
                2:       x = 16'd65025;
                3:       x = 16'd65024;
                4:       x = 16'd1;
                default: x = 16'($urandom);
            endcase
            send_b(x);
            t = 0;
            while (hs_b < i + 1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("b_handshake_seen", hs_b >= i + 1, 1);
        end
        b_done = 1'b1;
    end

    // Main driver A: reset, directed values, backpressure, abort, random.
    initial begin : drv_a
        int vals[9] = '{144, 143, 4095, 0, 1, 2, 3, 15, 16};
        int tgt;
        int t;
        int ov_seen;
        exp_t e;

        reset_a = 1'b1; in_valid_a = 1'b0; out_ready_a = 1'b1; x_a = 12'd0;
        repeat (3) @(negedge clk);
        reset_a = 1'b0;
        check("a_reset_in_ready", in_ready_a, 1);
        check("a_reset_out_valid", out_valid_a, 0);
        check("a_reset_root", root_a, 0);
        check("a_reset_rem", rem_a, 0);

        foreach (vals[i]) begin
            tgt = hs_a + 1;
            send_a(12'(vals[i]));
            wait_hs_a(tgt);
            @(negedge clk);
            check("a_in_ready_after_done", in_ready_a, 1);
        end

        // Backpressure: result held, new offers ignored.
        out_ready_a = 1'b0;
        send_a(12'd200);
        e = model(200, 0);
        t = 0;
        while (!out_valid_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("a_bp_out_valid_rise", out_valid_a, 1);
        repeat (10) begin
            check("a_bp_root_stable", root_a, e.root);
            check("a_bp_rem_stable", rem_a, e.rem);
            check("a_bp_in_ready_low", in_ready_a, 0);
            check("a_bp_out_valid_high", out_valid_a, 1);
            in_valid_a = 1'b1;
            x_a = 12'($urandom);
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        tgt = hs_a + 1;
        out_ready_a = 1'b1;
        wait_hs_a(tgt);
        @(negedge clk);
        @(negedge clk);
        check("a_bp_out_valid_cleared", out_valid_a, 0);
        check("a_bp_back_to_idle", in_ready_a, 1);

        // Reset on the third CALC cycle discards the operation.
        send_a(12'd3000);
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        check("a_abort_in_ready", in_ready_a, 1);
        check("a_abort_out_valid", out_valid_a, 0);
        check("a_abort_root", root_a, 0);
        check("a_abort_rem", rem_a, 0);
        q_a.delete();
        ov_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_a) ov_seen++;
        end
        check("a_abort_no_out_valid", ov_seen, 0);
        tgt = hs_a + 1;
        send_a(12'd25);
        wait_hs_a(tgt);

        // Random radicands with a randomly stalling consumer.
        for (int i = 0; i < 40; i++) begin
            tgt = hs_a + 1;
            send_a(12'($urandom_range(0, 4095)));
            t = 0;
            while (hs_a < tgt && t < 300) begin
                out_ready_a = 1'($urandom_range(0, 1));
                @(negedge clk);
                t++;
            end
            out_ready_a = 1'b1;
            wait_hs_a(tgt);
        end

        t = 0;
        while (!b_done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("b_finished", b_done, 1);
        repeat (12) @(negedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
